// File: rtl/replay_fifo_if.sv
// Handshake/status bundle for replay_fifo.
//  master : the producer/consumer side. It drives wrt/dataIn/rd/mark/restart/clrErr
//           and observes the data and status.
//  slave  : the FIFO itself.
interface replay_fifo_if #(
  parameter int ADDR_LEN = 5,
  parameter int DATA_LEN = 32
);
  logic                wrt;
  logic [DATA_LEN-1:0] dataIn;
  logic                rd;
  logic [DATA_LEN-1:0] dataOut;
  logic                mark;
  logic                restart;
  logic                clrErr;
  logic                empty;
  logic                full;
  logic                almostEmpty;
  logic                almostFull;
  logic [ADDR_LEN:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output wrt, dataIn, rd, mark, restart, clrErr,
    input  dataOut, empty, full, almostEmpty, almostFull, count, overflow, underflow
  );

  modport slave (
    input  wrt, dataIn, rd, mark, restart, clrErr,
    output dataOut, empty, full, almostEmpty, almostFull, count, overflow, underflow
  );
endinterface

// File: rtl/replay_fifo.sv
// Circular FIFO with checkpoint/replay.
// Entries are freed only when a mark commits the read position, never by a plain
// read. restart rewinds head to the checkpoint so that uncommitted data can be
// re-read. AUTO_MARK=1 makes the checkpoint follow head, which gives a plain FIFO.
// Ports:
//  clk    rising-edge clock
//  reset  asynchronous, active-low. Clears pointers, dataOut and flags; storage is kept.
//  bus    replay_fifo_if.slave: write/read/mark/restart/clrErr requests,
//         registered dataOut, occupancy and status flags
module replay_fifo #(
  parameter int ADDR_LEN  = 5,
  parameter int DATA_LEN  = 32,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 2,
  parameter int AUTO_MARK = 0
) (
  input logic         clk,
  input logic         reset,
  replay_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_LEN;
  typedef logic [ADDR_LEN:0] ptr_t;
  localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
  localparam ptr_t AFULL_P  = ptr_t'(AFULL_TH);
  localparam ptr_t AEMPTY_P = ptr_t'(AEMPTY_TH);

  logic [DATA_LEN-1:0] mem [DEPTH];

  // The extra MSB on each pointer tells a full buffer apart from an empty one.
  // All differences wrap modulo 2**(ADDR_LEN+1).
  ptr_t head, tail, chk;
  ptr_t headNext, chkNext, count, held;
  logic isFull, isEmpty, wrAcc, rdAcc, rstEff, markEff;
  logic [DATA_LEN-1:0] dataOutQ;
  logic ovfQ, unfQ;

  always_comb begin
    count   = tail - head;
    held    = tail - chk;
    isEmpty = (count == '0);
    // Fullness counts the committed window (held), not the readable count, so a
    // read alone never makes room for a write.
    isFull  = (held == DEPTH_P);
    rstEff  = (AUTO_MARK == 0) && bus.restart;
    // restart wins over mark. Under AUTO_MARK the checkpoint tracks head every cycle.
    markEff = (AUTO_MARK != 0) || (bus.mark && !rstEff);
    wrAcc   = bus.wrt && !isFull;
    rdAcc   = bus.rd && !isEmpty && !rstEff;
    headNext = rstEff ? chk : head + ptr_t'(rdAcc);
    // The commit includes a read accepted in the same cycle.
    chkNext  = markEff ? headNext : chk;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      chk      <= '0;
      dataOutQ <= '0;
      ovfQ     <= 1'b0;
      unfQ     <= 1'b0;
    end else begin
      head <= headNext;
      chk  <= chkNext;
      if (wrAcc) tail <= tail + ptr_t'(1);
      if (rdAcc) dataOutQ <= mem[head[ADDR_LEN-1:0]];
      // A new error event takes priority over a clear issued in the same cycle.
      if (bus.wrt && isFull)                 ovfQ <= 1'b1;
      else if (bus.clrErr)                   ovfQ <= 1'b0;
      if (bus.rd && isEmpty && !rstEff)      unfQ <= 1'b1;
      else if (bus.clrErr)                   unfQ <= 1'b0;
    end
  end

  // Storage is not reset. After a reset the pointers alone make old data unreachable.
  always_ff @(posedge clk) begin
    if (wrAcc) mem[tail[ADDR_LEN-1:0]] <= bus.dataIn;
  end

  assign bus.dataOut     = dataOutQ;
  assign bus.count       = count;
  assign bus.empty       = isEmpty;
  assign bus.full        = isFull;
  assign bus.almostEmpty = (count <= AEMPTY_P);
  assign bus.almostFull  = (held >= AFULL_P);
  assign bus.overflow    = ovfQ;
  assign bus.underflow   = unfQ;
endmodule

// File: tb/tb_replay_fifo.sv
// Directed bench for replay_fifo: u0 uses explicit mark/restart, u1 is built with AUTO_MARK=1.
module tb_replay_fifo;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  replay_fifo_if #(.ADDR_LEN(5), .DATA_LEN(32)) fa ();
  replay_fifo_if #(.ADDR_LEN(5), .DATA_LEN(32)) fb ();

  replay_fifo #(.ADDR_LEN(5), .DATA_LEN(32), .AFULL_TH(28), .AEMPTY_TH(2), .AUTO_MARK(0))
    u0 (.clk(clk), .reset(reset), .bus(fa));
  replay_fifo #(.ADDR_LEN(5), .DATA_LEN(32), .AFULL_TH(28), .AEMPTY_TH(2), .AUTO_MARK(1))
    u1 (.clk(clk), .reset(reset), .bus(fb));

  int nChk = 0;
  int nPass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clrIn();
    fa.wrt = 0; fa.dataIn = '0; fa.rd = 0; fa.mark = 0; fa.restart = 0; fa.clrErr = 0;
    fb.wrt = 0; fb.dataIn = '0; fb.rd = 0; fb.mark = 0; fb.restart = 0; fb.clrErr = 0;
  endtask

  // One cycle on unit u (0: u0, 1: u1). Outputs are sampled 1 time unit after the edge.
  task automatic op(input bit u, input bit w, input logic [31:0] d, input bit r,
                    input bit m, input bit rs, input bit ce);
    if (!u) begin
      fa.wrt = w; fa.dataIn = d; fa.rd = r; fa.mark = m; fa.restart = rs; fa.clrErr = ce;
    end else begin
      fb.wrt = w; fb.dataIn = d; fb.rd = r; fb.mark = m; fb.restart = rs; fb.clrErr = ce;
    end
    @(posedge clk); #1;
    clrIn();
  endtask

  task automatic wr(input bit u, input logic [31:0] d);
    op(u, 1, d, 0, 0, 0, 0);
  endtask

  task automatic rdo(input bit u);
    op(u, 0, '0, 1, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
  endtask

  initial begin
    clrIn();
    reset = 0;
    #12;
    // reset state
    chk("rst empty", fa.empty, 1);
    chk("rst full", fa.full, 0);
    chk("rst count", fa.count, 0);
    chk("rst aEmpty", fa.almostEmpty, 1);
    chk("rst aFull", fa.almostFull, 0);
    chk("rst ovf", fa.overflow, 0);
    chk("rst unf", fa.underflow, 0);
    chk("rst dout", fa.dataOut, 0);
    @(negedge clk) reset = 1;

    // fill to full, thresholds, overflow
    for (int i = 0; i < 32; i++) begin
      wr(0, i);
      chk("t1 count", fa.count, i + 1);
      chk("t1 aFull", fa.almostFull, (i + 1 >= 28) ? 1 : 0);
      chk("t1 aEmpty", fa.almostEmpty, (i + 1 <= 2) ? 1 : 0);
    end
    chk("t1 full", fa.full, 1);
    wr(0, 32'h99);
    chk("t1 ovf", fa.overflow, 1);
    chk("t1 count drop", fa.count, 32);
    op(0, 0, '0, 0, 0, 0, 1);
    chk("t1 clrErr", fa.overflow, 0);

    // reads keep held; mark frees
    for (int k = 0; k < 4; k++) begin
      rdo(0);
      chk("t2 dout", fa.dataOut, k);
      chk("t2 full", fa.full, 1);
      chk("t2 count", fa.count, 31 - k);
    end
    op(0, 0, '0, 0, 1, 0, 0);
    chk("t2 mark full", fa.full, 0);
    chk("t2 mark aFull", fa.almostFull, 1);
    wr(0, 32'hAA);
    chk("t2 wrAA count", fa.count, 29);
    chk("t2 wrAA full", fa.full, 0);
    for (int j = 0; j < 28; j++) begin
      rdo(0);
      chk("t2 drain", fa.dataOut, 4 + j);
    end
    rdo(0);
    chk("t2 AA", fa.dataOut, 32'hAA);
    chk("t2 empty", fa.empty, 1);

    // checkpoint / replay
    doReset();
    wr(0, 32'hA); wr(0, 32'hB); wr(0, 32'hC);
    op(0, 0, '0, 0, 1, 0, 0);
    rdo(0); chk("t3 rdA", fa.dataOut, 32'hA);
    rdo(0); chk("t3 rdB", fa.dataOut, 32'hB);
    chk("t3 count1", fa.count, 1);
    op(0, 0, '0, 0, 0, 1, 0);
    chk("t3 rewind count", fa.count, 3);
    chk("t3 rewind dout", fa.dataOut, 32'hB);
    rdo(0); chk("t3 replayA", fa.dataOut, 32'hA);
    op(0, 0, '0, 1, 0, 1, 0);
    chk("t3 rd+rs dout", fa.dataOut, 32'hA);
    chk("t3 rd+rs count", fa.count, 3);
    chk("t3 rd+rs unf", fa.underflow, 0);
    op(0, 0, '0, 1, 1, 0, 0);
    chk("t3 rd+mark dout", fa.dataOut, 32'hA);
    chk("t3 rd+mark count", fa.count, 2);
    rdo(0); chk("t3 rdB2", fa.dataOut, 32'hB);
    op(0, 0, '0, 0, 0, 1, 0);
    chk("t3 rewind2 count", fa.count, 2);
    rdo(0); chk("t3 replayB", fa.dataOut, 32'hB);

    // rd & wrt on empty
    doReset();
    op(0, 1, 32'h55, 1, 0, 0, 0);
    chk("t4 unf", fa.underflow, 1);
    chk("t4 count", fa.count, 1);
    chk("t4 dout", fa.dataOut, 0);
    rdo(0); chk("t4 rd55", fa.dataOut, 32'h55);
    chk("t4 empty", fa.empty, 1);
    op(0, 0, '0, 1, 0, 0, 1);
    chk("t4 set>clr", fa.underflow, 1);
    op(0, 0, '0, 0, 0, 0, 1);
    chk("t4 clr", fa.underflow, 0);

    // wrap, explicit mark (u0) and auto-mark (u1)
    doReset();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) wr(0, p * 100 + i);
      chk("t5 count20", fa.count, 20);
      for (int i = 0; i < 20; i++) begin
        op(0, 0, '0, 1, 1, 0, 0);
        chk("t5 dout", fa.dataOut, p * 100 + i);
      end
      chk("t5 empty", fa.empty, 1);
      chk("t5 full", fa.full, 0);
    end
    for (int i = 0; i < 32; i++) wr(0, 32'h1000 + i);
    chk("t5 refill full", fa.full, 1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) wr(1, p * 100 + i);
      chk("t5a count20", fb.count, 20);
      for (int i = 0; i < 20; i++) begin
        rdo(1);
        chk("t5a dout", fb.dataOut, p * 100 + i);
      end
      chk("t5a empty", fb.empty, 1);
    end
    for (int i = 0; i < 32; i++) wr(1, 32'h1000 + i);
    chk("t5a full", fb.full, 1);
    rdo(1);
    chk("t5a rd dout", fb.dataOut, 32'h1000);
    chk("t5a rd frees", fb.full, 0);
    chk("t5a count", fb.count, 31);
    op(1, 0, '0, 1, 0, 1, 0);
    chk("t5a rs ignored", fb.dataOut, 32'h1001);
    chk("t5a rs count", fb.count, 30);

    // asynchronous reset mid-burst
    doReset();
    wr(0, 1); wr(0, 2); wr(0, 3);
    rdo(0); chk("t6 pre dout", fa.dataOut, 1);
    fa.wrt = 1; fa.dataIn = 32'h4;
    @(posedge clk); #3 reset = 0;
    #1;
    chk("t6 async empty", fa.empty, 1);
    chk("t6 async count", fa.count, 0);
    chk("t6 async dout", fa.dataOut, 0);
    clrIn();
    @(negedge clk) reset = 1;
    wr(0, 32'h77);
    chk("t6 post count", fa.count, 1);
    rdo(0); chk("t6 post dout", fa.dataOut, 32'h77);
    chk("t6 post empty", fa.empty, 1);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
